// File: rtl/sc_config_scheduler.sv
// Double-buffered scanconverter configuration: eight shadow words written by software,
// copied to the active outputs on a vsync falling edge, on request, or after a timeout.
//
// state   | meaning
// IDLE    | shadow writable, no commit outstanding
// PENDING | commit accepted, shadow frozen, waiting for vsync / apply_now / timeout
module sc_config_scheduler #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000
) (
  input  logic        PCLK_i,
  input  logic        reset_i,
  input  logic        cfg_wr_i,
  input  logic [2:0]  cfg_addr_i,
  input  logic [31:0] cfg_wdata_i,
  output logic [31:0] cfg_rdata_o,
  input  logic        commit_req_i,
  input  logic        apply_now_i,
  input  logic        VSYNC_i,
  output logic [31:0] hv_out_config_o,
  output logic [31:0] hv_out_config2_o,
  output logic [31:0] hv_out_config3_o,
  output logic [31:0] xy_out_config_o,
  output logic [31:0] xy_out_config2_o,
  output logic [31:0] misc_config_o,
  output logic [31:0] sl_config_o,
  output logic [31:0] sl_config2_o,
  output logic        commit_pending_o,
  output logic        commit_ack_o,
  output logic        timeout_o,
  output logic        wr_err_o
);

  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [23:0] TO_LAST = TIMEOUT_CYCLES - 24'd1;

  state_t      state, state_nxt;
  logic [31:0] shadow     [8];
  logic [31:0] shadow_nxt [8];
  logic [31:0] active     [8];
  logic [23:0] to_cnt;
  logic        vs_prev;
  logic        sync_arm;
  logic        sync_edge;
  logic        shadow_we;
  logic        apply;
  logic        forced;

  // sync_arm masks the first edge after reset so a vsync already low is not seen as falling
  assign sync_edge = sync_arm & vs_prev & ~VSYNC_i;
  assign shadow_we = (state == IDLE) & cfg_wr_i;

  always_comb begin
    for (int i = 0; i < 8; i++) shadow_nxt[i] = shadow[i];
    if (shadow_we) shadow_nxt[cfg_addr_i] = cfg_wdata_i;
  end

  always_ff @(posedge PCLK_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    apply     = 1'b0;
    forced    = 1'b0;
    case (state)
      IDLE: begin
        if (commit_req_i) begin
          if (apply_now_i) apply     = 1'b1;
          else             state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (sync_edge || apply_now_i) begin
          apply     = 1'b1;
          state_nxt = IDLE;
        end else if (to_cnt == TO_LAST) begin
          apply     = 1'b1;
          forced    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < 8; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      to_cnt       <= '0;
      vs_prev      <= 1'b1;
      sync_arm     <= 1'b0;
      commit_ack_o <= 1'b0;
      timeout_o    <= 1'b0;
      wr_err_o     <= 1'b0;
    end else begin
      for (int i = 0; i < 8; i++) shadow[i] <= shadow_nxt[i];
      if (apply) begin
        for (int i = 0; i < 8; i++) active[i] <= shadow_nxt[i];
      end
      // counter runs only while pending; IDLE holds it at zero so each commit starts fresh
      to_cnt       <= (state == PENDING) ? to_cnt + 24'd1 : 24'd0;
      vs_prev      <= VSYNC_i;
      sync_arm     <= 1'b1;
      commit_ack_o <= apply;
      timeout_o    <= forced;
      wr_err_o     <= (state == PENDING) & cfg_wr_i;
    end
  end

  assign cfg_rdata_o      = shadow[cfg_addr_i];
  assign commit_pending_o = (state == PENDING);

  assign hv_out_config_o  = active[0];
  assign hv_out_config2_o = active[1];
  assign hv_out_config3_o = active[2];
  assign xy_out_config_o  = active[3];
  assign xy_out_config2_o = active[4];
  assign misc_config_o    = active[5];
  assign sl_config_o      = active[6];
  assign sl_config2_o     = active[7];

endmodule
